// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: load-type codes, multiply/divide
// buffer entries and the little-endian load extractor.
package wb_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4
  } load_type_e;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } md_entry_t;

  // Byte lane from addr[1:0], half lane from addr[1]; unknown codes act as LW.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  addr,
                                               input logic [2:0]  lt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (load_type_e'(lt))
      LB:      r = {{24{b[7]}}, b};
      LBU:     r = {24'd0, b};
      LH:      r = {{16{h[15]}}, h};
      LHU:     r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_wb_fifo.sv
// Synchronous FIFO buffering multiply/divide results until a pipeline bubble
// frees the register-file write port. Power-of-two depth, wrap-around pointers.
module md_wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  md_entry_t                push_data,
  input  logic                     pop,
  output md_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  md_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register with load extraction and arbitration of the register file's
// single write port between the pipeline (priority) and the mul/div buffer.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int MD_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_m,
  input  logic                        RegWriteM,
  input  logic                        MemtoRegM,
  input  logic [4:0]                  rwM,
  input  logic [31:0]                 alu_outM,
  input  logic [31:0]                 read_dataM,
  input  logic [1:0]                  addrM,
  input  logic [2:0]                  load_typeM,
  input  logic                        md_valid,
  input  logic [4:0]                  md_rw,
  input  logic [31:0]                 md_result,
  output logic                        md_ready,
  output logic [31:0]                 WBSrc,
  output logic [4:0]                  rwW,
  output logic                        RegWriteW,
  output logic [$clog2(MD_DEPTH):0]   md_count
);

  logic      pw;
  logic      md_push;
  logic      md_pop;
  logic      md_full;
  logic      md_empty;
  md_entry_t md_head;
  md_entry_t md_in;
  logic [31:0] mem_data;

  // Handshake: a result transfers on a cycle where md_valid & md_ready are both
  // high; md_ready depends only on buffer state (not full), never on md_valid.
  assign md_ready = ~md_full;
  assign pw       = valid_m & RegWriteM & (rwM != 5'd0);
  // r0 results are accepted but never stored, so they cannot reach the port.
  assign md_push  = md_valid & md_ready & (md_rw != 5'd0);
  assign md_pop   = ~pw & ~md_empty & (md_head.rw != 5'd0);
  assign md_in    = '{rw: md_rw, data: md_result};
  assign mem_data = MemtoRegM ? extract_load(read_dataM, addrM, load_typeM) : alu_outM;

  md_wb_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (md_push),
    .push_data (md_in),
    .pop       (md_pop),
    .head      (md_head),
    .full      (md_full),
    .empty     (md_empty),
    .count     (md_count)
  );

  // Outputs come straight from flops so the level-sensitive register file
  // never sees combinational glitches; data/address hold during bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WBSrc     <= '0;
      rwW       <= '0;
      RegWriteW <= 1'b0;
    end else if (pw) begin
      WBSrc     <= mem_data;
      rwW       <= rwM;
      RegWriteW <= 1'b1;
    end else if (md_pop) begin
      WBSrc     <= md_head.data;
      rwW       <= md_head.rw;
      RegWriteW <= 1'b1;
    end else begin
      RegWriteW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboarded bench for writeback_stage: directed plan cases plus random
// traffic, predicted by a queue-based reference model.
module tb_writeback_stage;
  import wb_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, RegWriteM, MemtoRegM;
  logic [4:0]  rwM;
  logic [31:0] alu_outM, read_dataM;
  logic [1:0]  addrM;
  logic [2:0]  load_typeM;
  logic        md_valid;
  logic [4:0]  md_rw;
  logic [31:0] md_result;
  logic        md_ready;
  logic [31:0] WBSrc;
  logic [4:0]  rwW;
  logic        RegWriteW;
  logic [$clog2(DEPTH):0] md_count;

  writeback_stage #(.MD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .rwM(rwM), .alu_outM(alu_outM), .read_dataM(read_dataM),
    .addrM(addrM), .load_typeM(load_typeM), .md_valid(md_valid), .md_rw(md_rw),
    .md_result(md_result), .md_ready(md_ready), .WBSrc(WBSrc), .rwW(rwW),
    .RegWriteW(RegWriteW), .md_count(md_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish within budget");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];     // {cycle[31:0], rw[4:0], data[31:0]}
  logic [36:0] model_q[$];   // reference mul/div buffer {rw, data}
  logic [4:0]  last_rw = '0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load extraction written as shifts and masks.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] addr,
                                           input logic [2:0] lt);
    logic [31:0] v;
    case (lt)
      3'd1: begin v = (word >> (int'(addr) * 8)) & 32'hFF; if (v >= 32'd128) v = v - 32'd256; end
      3'd2: v = (word >> (int'(addr) * 8)) & 32'hFF;
      3'd3: begin v = (word >> (int'(addr[1]) * 16)) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd4: v = (word >> (int'(addr[1]) * 16)) & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic rwe, input logic mtr, input logic [4:0] rw,
                      input logic [31:0] alu, input logic [31:0] rd, input logic [1:0] a,
                      input logic [2:0] lt, input logic mv, input logic [4:0] mrw,
                      input logic [31:0] mres);
    logic        ready_m;
    logic [36:0] e;
    @(negedge clk);
    valid_m = v; RegWriteM = rwe; MemtoRegM = mtr; rwM = rw; alu_outM = alu;
    read_dataM = rd; addrM = a; load_typeM = lt; md_valid = mv; md_rw = mrw; md_result = mres;
    #1;
    ready_m = (model_q.size() < DEPTH);
    check("md_ready", 32'(md_ready), 32'(ready_m));
    check("md_count", 32'(md_count), 32'(model_q.size()));
    if (v && rwe && rw != 5'd0)
      exp_q.push_back({32'(cyc + 1), rw, (mtr ? ref_load(rd, a, lt) : alu)});
    else if (model_q.size() > 0) begin
      e = model_q.pop_front();
      exp_q.push_back({32'(cyc + 1), e});
    end
    if (mv && ready_m && mrw != 5'd0) model_q.push_back({mrw, mres});
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 3'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wbsrc"}, WBSrc, 32'd0);
    check({tag, "_rww"}, 32'(rwW), 32'd0);
    check({tag, "_regwritew"}, 32'(RegWriteW), 32'd0);
    check({tag, "_md_ready"}, 32'(md_ready), 32'd1);
    check({tag, "_md_count"}, 32'(md_count), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [68:0] e;
    if (!reset) begin
      last_rw = '0;
      last_data = '0;
    end else if (RegWriteW) begin
      check("rw_nonzero", 32'(rwW != 5'd0), 32'd1);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_write: got rw=%0d data=%h expected no write (cycle %0d)", rwW, WBSrc, cyc);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 32'(cyc), e[68:37]);
        check("write_rw", 32'(rwW), 32'(e[36:32]));
        check("write_data", WBSrc, e[31:0]);
        last_rw = e[36:32];
        last_data = e[31:0];
      end
    end else begin
      if (exp_q.size() > 0 && int'(exp_q[0][68:37]) <= cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: got no write expected rw=%0d data=%h (cycle %0d)", e[36:32], e[31:0], cyc);
      end
      check("hold_rw", 32'(rwW), 32'(last_rw));
      check("hold_data", WBSrc, last_data);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    valid_m = 0; RegWriteM = 0; MemtoRegM = 0; rwM = 0; alu_outM = 0; read_dataM = 0;
    addrM = 0; load_typeM = 0; md_valid = 0; md_rw = 0; md_result = 0;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    // ALU write and the four plan load extractions
    step(1, 1, 0, 5'd5, 32'h1234_5678, 32'h0, 2'd0, 3'd0, 0, 5'd0, 32'd0);
    step(1, 1, 1, 5'd6, 32'h0, 32'h80FF_7F01, 2'd3, 3'd1, 0, 5'd0, 32'd0);
    step(1, 1, 1, 5'd7, 32'h0, 32'h80FF_7F01, 2'd2, 3'd2, 0, 5'd0, 32'd0);
    step(1, 1, 1, 5'd8, 32'h0, 32'h80FF_7F01, 2'd2, 3'd3, 0, 5'd0, 32'd0);
    step(1, 1, 1, 5'd9, 32'h0, 32'h80FF_7F01, 2'd0, 3'd4, 0, 5'd0, 32'd0);
    step(1, 1, 1, 5'd10, 32'h0, 32'h80FF_7F01, 2'd1, 3'd7, 0, 5'd0, 32'd0);
    idle();

    // mul/div result held back by three busy cycles
    step(1, 1, 0, 5'd1, 32'hA, 32'h0, 2'd0, 3'd0, 1, 5'd9, 32'hDEAD_BEEF);
    step(1, 1, 0, 5'd2, 32'hB, 32'h0, 2'd0, 3'd0, 0, 5'd0, 32'd0);
    step(1, 1, 0, 5'd3, 32'hC, 32'h0, 2'd0, 3'd0, 0, 5'd0, 32'd0);
    idle(); idle(); idle();

    // fill the buffer; third offer must be refused
    step(1, 1, 0, 5'd4, 32'h1, 32'h0, 2'd0, 3'd0, 1, 5'd10, 32'h1111_0000);
    step(1, 1, 0, 5'd4, 32'h2, 32'h0, 2'd0, 3'd0, 1, 5'd11, 32'h2222_0000);
    step(1, 1, 0, 5'd4, 32'h3, 32'h0, 2'd0, 3'd0, 1, 5'd12, 32'h3333_0000);
    idle(); idle(); idle(); idle();

    // r0 destinations from both sources
    step(1, 1, 0, 5'd0, 32'h5, 32'h0, 2'd0, 3'd0, 1, 5'd0, 32'h6);
    idle(); idle();

    // asynchronous reset with a full buffer and a live write
    step(1, 1, 0, 5'd13, 32'h77, 32'h0, 2'd0, 3'd0, 1, 5'd14, 32'h88);
    step(1, 1, 0, 5'd15, 32'h99, 32'h0, 2'd0, 3'd0, 1, 5'd16, 32'hAA);
    #1;
    check("pre_reset_count", 32'(md_count), 32'd2);
    check("pre_reset_write", 32'(RegWriteW), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    model_q.delete();
    valid_m = 0; md_valid = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (4) idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8), $urandom_range(0, 1),
           5'($urandom_range(0, 31)), $urandom, $urandom, 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4),
           (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31))), $urandom);
    end
    repeat (DEPTH + 3) idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
